// File: rtl/dac_seq_pkg.sv
// dac_seq_pkg: shared state encoding, command-field width and frame-size helper for the DAC sequencer
package dac_seq_pkg;
   localparam int CMD_W = 8;
   localparam logic [7:0] DEF_ADDR_BASE = 8'h04;
   typedef enum logic [2:0] {
      S_IDLE, S_SCAN, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_LOAD, S_FIN
   } state_t;
   function automatic int frame_width(input int data_w);
      return CMD_W + data_w;
   endfunction
endpackage

// File: rtl/dac_frame_shifter.sv
// dac_frame_shifter: MSB-first serializer with SCLK divider, shift register and half-period counter
// Ports: clk/rst (sync active-high); load captures frame; start begins shifting with a falling
// SCLK edge; div = half period minus 1; sclk idles high; sdi = shift MSB; done pulses during
// the final cycle of the last high half period.
module dac_frame_shifter
   import dac_seq_pkg::*;
#(
   parameter int FRAME_W = 24
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               start,
   input  logic [FRAME_W-1:0] frame,
   input  logic [7:0]         div,
   output logic               sclk,
   output logic               sdi,
   output logic               done
);
   localparam int HW = $clog2(2*FRAME_W);
   logic [FRAME_W-1:0] sh_q, sh_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [HW-1:0]      half_q, half_d;
   logic               act_q, act_d, sclk_q, sclk_d, tick;
   assign tick = act_q && cnt_q == div;
   assign done = tick && half_q == HW'(2*FRAME_W-1);
   assign sclk = sclk_q;
   assign sdi  = sh_q[FRAME_W-1];
   // Even half periods are SCLK low; data advances on each rising edge.
   always_comb begin
      sh_d   = load ? frame : sh_q;
      cnt_d  = cnt_q;
      half_d = half_q;
      act_d  = act_q;
      sclk_d = sclk_q;
      if (start) begin
         act_d  = 1'b1;
         sclk_d = 1'b0;
         cnt_d  = '0;
         half_d = '0;
      end else if (act_q) begin
         cnt_d = tick ? '0 : cnt_q + 8'd1;
         if (tick) begin
            half_d = half_q + HW'(1);
            sclk_d = done | ~sclk_q;
            act_d  = !done;
            if (!sclk_q) sh_d = sh_q << 1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q   <= '0;
         cnt_q  <= '0;
         half_q <= '0;
         act_q  <= 1'b0;
         sclk_q <= 1'b1;
      end else begin
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         half_q <= half_d;
         act_q  <= act_d;
         sclk_q <= sclk_d;
      end
   end
endmodule

// File: rtl/dac_frame_sequencer.sv
// dac_frame_sequencer: shadow-register bank that streams dirty channels to daisy-less multi-device DACs
// Ports: CLK_100MHz/RESET (sync active-high); WR_* shadow writes (WR_BCAST = all channels);
// RESYNC marks all dirty; START runs one batch; AUTO_LOAD pulses DAC_nLOAD at batch end;
// CLK_DIV = SCLK half period minus 1; RD_ADDR/RD_DATA combinational readback; DIRTY_MASK,
// BUSY, DONE status; DAC_SCLK/DAC_nCS per device, DAC_SDI/DAC_nLOAD shared.
module dac_frame_sequencer
   import dac_seq_pkg::*;
#(
   parameter int         NUM_DEV    = 5,
   parameter int         CH_PER_DEV = 4,
   parameter int         DATA_W     = 16,
   parameter logic [7:0] ADDR_BASE  = DEF_ADDR_BASE,
   parameter int         LOAD_W     = 4,
   localparam int        NCH        = NUM_DEV*CH_PER_DEV,
   localparam int        FRAME_W    = frame_width(DATA_W),
   localparam int        AW         = NCH > 1 ? $clog2(NCH) : 1
)(
   input  logic              CLK_100MHz,
   input  logic              RESET,
   input  logic              WR_EN,
   input  logic [AW-1:0]     WR_ADDR,
   input  logic [DATA_W-1:0] WR_DATA,
   input  logic              WR_BCAST,
   input  logic              RESYNC,
   input  logic              START,
   input  logic              AUTO_LOAD,
   input  logic [7:0]        CLK_DIV,
   input  logic [AW-1:0]     RD_ADDR,
   output logic [DATA_W-1:0] RD_DATA,
   output logic [NCH-1:0]    DIRTY_MASK,
   output logic              BUSY,
   output logic              DONE,
   output logic [NUM_DEV-1:0] DAC_SCLK,
   output logic [NUM_DEV-1:0] DAC_nCS,
   output logic              DAC_SDI,
   output logic              DAC_nLOAD
);
   localparam int PW = $clog2(NCH+1);
   localparam int DW = NUM_DEV > 1 ? $clog2(NUM_DEV) : 1;
   state_t              state_q, state_d;
   logic [DATA_W-1:0]   shadow_q [NCH];
   logic [DATA_W-1:0]   shadow_d [NCH];
   logic [NCH-1:0]      dirty_q, dirty_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [DW-1:0]       dev_q, dev_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                sent_q, sent_d;
   logic                found, load, start_sh, sh_done, sh_sclk, half_end, cs_on;
   logic [AW-1:0]       idx;
   logic [FRAME_W-1:0]  frame;
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = NCH-1; i >= 0; i--)
         if (dirty_q[i] && PW'(i) >= ptr_q) begin
            found = 1'b1;
            idx   = AW'(i);
         end
   end
   assign frame    = {ADDR_BASE + 8'(int'(idx) % CH_PER_DEV), shadow_q[idx]};
   assign half_end = cnt_q == CLK_DIV;
   assign load     = state_q == S_SCAN && found;
   assign start_sh = state_q == S_SETUP && half_end;
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      dev_d    = dev_q;
      sent_d   = sent_q;
      dirty_d  = dirty_q;
      shadow_d = shadow_q;
      case (state_q)
         S_IDLE:  if (START) begin
            state_d = S_SCAN;
            ptr_d   = '0;
            sent_d  = 1'b0;
         end
         S_SCAN:  if (found) begin
            state_d      = S_SETUP;
            ptr_d        = PW'(idx) + PW'(1);
            dev_d        = DW'(int'(idx) / CH_PER_DEV);
            sent_d       = 1'b1;
            dirty_d[idx] = 1'b0;
         end else state_d = AUTO_LOAD && sent_q ? S_LOAD : S_FIN;
         S_SETUP: state_d = half_end ? S_SHIFT : S_SETUP;
         S_SHIFT: state_d = sh_done ? S_HOLD : S_SHIFT;
         S_HOLD:  state_d = half_end ? S_GAP : S_HOLD;
         S_GAP:   state_d = half_end ? S_SCAN : S_GAP;
         S_LOAD:  state_d = cnt_q == 8'(LOAD_W-1) ? S_FIN : S_LOAD;
         default: state_d = S_IDLE;
      endcase
      // Writes are applied after the capture clear so a same-cycle write keeps the channel dirty.
      if (RESYNC) dirty_d = '1;
      if (WR_EN && WR_BCAST) begin
         dirty_d = '1;
         for (int i = 0; i < NCH; i++) shadow_d[i] = WR_DATA;
      end else if (WR_EN && int'(WR_ADDR) < NCH) begin
         dirty_d[WR_ADDR]  = 1'b1;
         shadow_d[WR_ADDR] = WR_DATA;
      end
   end
   assign cnt_d = state_d != state_q ? '0 : cnt_q + 8'd1;
   always_ff @(posedge CLK_100MHz) begin
      if (RESET) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         dev_q   <= '0;
         sent_q  <= 1'b0;
         dirty_q <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < NCH; i++) shadow_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         dev_q    <= dev_d;
         sent_q   <= sent_d;
         dirty_q  <= dirty_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
      end
   end
   dac_frame_shifter #(.FRAME_W(FRAME_W)) u_shifter (
      .clk   (CLK_100MHz),
      .rst   (RESET),
      .load  (load),
      .start (start_sh),
      .frame (frame),
      .div   (CLK_DIV),
      .sclk  (sh_sclk),
      .sdi   (DAC_SDI),
      .done  (sh_done)
   );
   assign cs_on      = state_q == S_SETUP || state_q == S_SHIFT || state_q == S_HOLD;
   assign BUSY       = state_q != S_IDLE;
   assign DONE       = state_q == S_FIN;
   assign DAC_nLOAD  = state_q != S_LOAD;
   assign DIRTY_MASK = dirty_q;
   assign RD_DATA    = int'(RD_ADDR) < NCH ? shadow_q[RD_ADDR] : '0;
   for (genvar d = 0; d < NUM_DEV; d++) begin : g_dev
      assign DAC_nCS[d]  = !(cs_on && dev_q == DW'(d));
      assign DAC_SCLK[d] = sh_sclk || dev_q != DW'(d);
   end
endmodule

// File: tb/tb_dac_frame_sequencer.sv
// tb_dac_frame_sequencer: directed scenarios against a serial-DAC monitor model
module tb_dac_frame_sequencer;
   logic        clk = 0, rst = 0, wr_en = 0, wr_bcast = 0, resync = 0, start = 0, auto_load = 0;
   logic [4:0]  wr_addr = 0, rd_addr = 0;
   logic [15:0] wr_data = 0;
   logic [7:0]  clk_div = 8'd1;
   logic [15:0] rd_data;
   logic [19:0] dirty;
   logic        busy, done, sdi, nload;
   logic [4:0]  sclk, ncs;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   dac_frame_sequencer #(.NUM_DEV(5), .CH_PER_DEV(4), .DATA_W(16), .ADDR_BASE(8'h04), .LOAD_W(4)) dut (
      .CLK_100MHz(clk), .RESET(rst), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
      .WR_BCAST(wr_bcast), .RESYNC(resync), .START(start), .AUTO_LOAD(auto_load),
      .CLK_DIV(clk_div), .RD_ADDR(rd_addr), .RD_DATA(rd_data), .DIRTY_MASK(dirty),
      .BUSY(busy), .DONE(done), .DAC_SCLK(sclk), .DAC_nCS(ncs), .DAC_SDI(sdi), .DAC_nLOAD(nload)
   );
   typedef struct {
      int          dev;
      logic [23:0] data;
      int          nbits;
      int          len;
      int          minsp;
      int          maxsp;
   } frame_t;
   frame_t fq[$];
   frame_t cur;
   int cur_dev = -1, last_fall = -1, cyc = 0;
   int done_cnt = 0, nl_cnt = 0, nl_len = 0, nl_last = 0, multi_cs = 0, stray = 0;
   logic prev_sclk = 1;
   // DAC-side model: samples SDI on each falling SCLK of the selected device.
   always @(negedge clk) begin
      cyc++;
      if (done) done_cnt++;
      if (!nload) nl_len++;
      else if (nl_len > 0) begin
         nl_cnt++;
         nl_last = nl_len;
         nl_len = 0;
      end
      if ($countones(~ncs) > 1) multi_cs++;
      for (int d = 0; d < 5; d++) if (!sclk[d] && ncs[d]) stray++;
      if (cur_dev >= 0 && ncs[cur_dev]) begin
         fq.push_back(cur);
         cur_dev = -1;
      end
      if (cur_dev < 0 && ncs != 5'h1f)
         for (int d = 0; d < 5; d++) if (!ncs[d]) begin
            cur_dev = d;
            cur.dev = d; cur.data = 0; cur.nbits = 0; cur.len = 0; cur.minsp = 1000; cur.maxsp = 0;
            prev_sclk = 1;
            last_fall = -1;
         end
      if (cur_dev >= 0) begin
         cur.len++;
         if (prev_sclk && !sclk[cur_dev]) begin
            cur.data = {cur.data[22:0], sdi};
            cur.nbits++;
            if (last_fall >= 0) begin
               if (cyc - last_fall < cur.minsp) cur.minsp = cyc - last_fall;
               if (cyc - last_fall > cur.maxsp) cur.maxsp = cyc - last_fall;
            end
            last_fall = cyc;
         end
         prev_sclk = sclk[cur_dev];
      end
   end
   task automatic tick();
      @(posedge clk); #1;
   endtask
   task automatic wr(input logic [4:0] a, input logic [15:0] v, input logic b);
      wr_en = 1; wr_addr = a; wr_data = v; wr_bcast = b;
      tick();
      wr_en = 0; wr_bcast = 0;
   endtask
   task automatic pulse_start();
      start = 1;
      tick();
      start = 0;
   endtask
   task automatic wait_done(input int budget, input int d0);
      int n = 0;
      while (done_cnt == d0 && n < budget) begin
         tick();
         n++;
      end
      total++;
      if (done_cnt == d0) begin bad++; $display("FAIL done_timeout: no DONE within %0d cycles", budget); end
      repeat (3) tick();
   endtask
   task automatic test_reset();
      rst = 1; tick(); tick(); rst = 0; rd_addr = 0; #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
      total++; if (ncs !== 5'h1f) begin bad++; $display("FAIL rst_ncs: got %h want 1f", ncs); end
      total++; if (sclk !== 5'h1f) begin bad++; $display("FAIL rst_sclk: got %h want 1f", sclk); end
      total++; if (sdi !== 1'b0) begin bad++; $display("FAIL rst_sdi: got %b want 0", sdi); end
      total++; if (nload !== 1'b1) begin bad++; $display("FAIL rst_nload: got %b want 1", nload); end
      total++; if (dirty !== 20'h0) begin bad++; $display("FAIL rst_dirty: got %h want 0", dirty); end
      total++; if (rd_data !== 16'h0) begin bad++; $display("FAIL rst_rd: got %h want 0", rd_data); end
   endtask
   task automatic test_single();
      int b, d0, n0;
      wr(5'd25, 16'hBEEF, 0);
      total++; if (dirty !== 20'h0) begin bad++; $display("FAIL oob_write: got %h want 0", dirty); end
      wr(5'd6, 16'h1234, 0);
      rd_addr = 6; #1;
      total++; if (rd_data !== 16'h1234) begin bad++; $display("FAIL single_rd: got %h want 1234", rd_data); end
      total++; if (dirty !== 20'h40) begin bad++; $display("FAIL single_dirty: got %h want 00040", dirty); end
      b = fq.size(); d0 = done_cnt; n0 = nl_cnt; auto_load = 1;
      pulse_start();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
      wait_done(400, d0);
      total++; if (fq.size() - b != 1) begin bad++; $display("FAIL single_count: got %0d want 1", fq.size() - b); end
      total++; if (fq[b].dev != 1 || fq[b].data !== 24'h061234) begin bad++; $display("FAIL single_frame: got dev %0d data %h want dev 1 data 061234", fq[b].dev, fq[b].data); end
      total++; if (fq[b].nbits != 24 || fq[b].len != 100) begin bad++; $display("FAIL single_timing: got bits %0d ncs_len %0d want 24 100", fq[b].nbits, fq[b].len); end
      total++; if (fq[b].minsp != 4 || fq[b].maxsp != 4) begin bad++; $display("FAIL single_period: got %0d..%0d want 4..4", fq[b].minsp, fq[b].maxsp); end
      total++; if (nl_cnt - n0 != 1 || nl_last != 4) begin bad++; $display("FAIL single_nload: got %0d pulses len %0d want 1 len 4", nl_cnt - n0, nl_last); end
      total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL single_donecnt: got %0d want 1", done_cnt - d0); end
      total++; if (dirty !== 20'h0 || busy !== 1'b0) begin bad++; $display("FAIL single_end: got dirty %h busy %b want 0 0", dirty, busy); end
   endtask
   task automatic test_broadcast();
      int b, d0, n0;
      logic [23:0] exp;
      wr(5'd0, 16'h8000, 1);
      total++; if (dirty !== 20'hfffff) begin bad++; $display("FAIL bcast_dirty: got %h want fffff", dirty); end
      b = fq.size(); d0 = done_cnt; n0 = nl_cnt;
      pulse_start();
      wait_done(5000, d0);
      total++; if (fq.size() - b != 20) begin bad++; $display("FAIL bcast_count: got %0d want 20", fq.size() - b); end
      for (int i = 0; i < 20; i++) begin
         exp = {8'(4 + i % 4), 16'h8000};
         total++; if (fq[b+i].dev != i / 4 || fq[b+i].data !== exp) begin bad++; $display("FAIL bcast_frame%0d: got dev %0d data %h want dev %0d data %h", i, fq[b+i].dev, fq[b+i].data, i / 4, exp); end
      end
      total++; if (nl_cnt - n0 != 1) begin bad++; $display("FAIL bcast_nload: got %0d want 1", nl_cnt - n0); end
      total++; if (dirty !== 20'h0) begin bad++; $display("FAIL bcast_end_dirty: got %h want 0", dirty); end
   endtask
   task automatic test_empty();
      int b, n0;
      b = fq.size(); n0 = nl_cnt;
      pulse_start();
      total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL empty_c1: got busy %b done %b want 1 0", busy, done); end
      tick();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL empty_c2_done: got %b want 1", done); end
      tick();
      total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL empty_c3: got done %b busy %b want 0 0", done, busy); end
      repeat (3) tick();
      total++; if (fq.size() != b || nl_cnt != n0) begin bad++; $display("FAIL empty_activity: got frames %0d nload %0d want 0 0", fq.size() - b, nl_cnt - n0); end
   endtask
   task automatic test_capture_race();
      int b, d0, n0;
      auto_load = 0;
      wr(5'd3, 16'h1111, 0);
      b = fq.size(); d0 = done_cnt; n0 = nl_cnt;
      pulse_start();
      wr(5'd3, 16'hAAAA, 0);
      wait_done(400, d0);
      rd_addr = 3; #1;
      total++; if (fq.size() - b != 1 || fq[b].data !== 24'h071111) begin bad++; $display("FAIL race_old: got %0d frames data %h want 1 071111", fq.size() - b, fq[b].data); end
      total++; if (dirty !== 20'h8) begin bad++; $display("FAIL race_dirty: got %h want 00008", dirty); end
      total++; if (rd_data !== 16'hAAAA) begin bad++; $display("FAIL race_rd: got %h want aaaa", rd_data); end
      total++; if (nl_cnt != n0) begin bad++; $display("FAIL race_noload: got %0d pulses want 0", nl_cnt - n0); end
      b = fq.size(); d0 = done_cnt;
      pulse_start();
      wait_done(400, d0);
      total++; if (fq.size() - b != 1 || fq[b].data !== 24'h07AAAA) begin bad++; $display("FAIL race_new: got %0d frames data %h want 1 07aaaa", fq.size() - b, fq[b].data); end
      total++; if (dirty !== 20'h0) begin bad++; $display("FAIL race_end_dirty: got %h want 0", dirty); end
   endtask
   task automatic test_reset_mid();
      int b, d0, n;
      wr(5'd10, 16'h5555, 0);
      pulse_start();
      n = 0;
      while (sclk[2] !== 1'b0 && n < 50) begin tick(); n++; end
      total++; if (sclk[2] !== 1'b0) begin bad++; $display("FAIL mid_reach_shift: got sclk %h want bit2 low", sclk); end
      rd_addr = 10; rst = 1; tick(); rst = 0;
      total++; if (ncs !== 5'h1f || sclk !== 5'h1f) begin bad++; $display("FAIL mid_pins: got ncs %h sclk %h want 1f 1f", ncs, sclk); end
      total++; if (busy !== 1'b0 || sdi !== 1'b0 || nload !== 1'b1) begin bad++; $display("FAIL mid_state: got busy %b sdi %b nload %b want 0 0 1", busy, sdi, nload); end
      total++; if (rd_data !== 16'h0 || dirty !== 20'h0) begin bad++; $display("FAIL mid_regs: got rd %h dirty %h want 0 0", rd_data, dirty); end
      wr(5'd0, 16'h0001, 0);
      b = fq.size(); d0 = done_cnt;
      pulse_start();
      repeat (10) tick();
      pulse_start();
      wait_done(400, d0);
      repeat (20) tick();
      total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL busy_start_done: got %0d want 1", done_cnt - d0); end
      total++; if (fq.size() - b != 1 || fq[b].data !== 24'h040001) begin bad++; $display("FAIL busy_start_frames: got %0d data %h want 1 040001", fq.size() - b, fq[b].data); end
   endtask
   task automatic test_fast_div();
      int b, d0, n0;
      logic [23:0] exp;
      clk_div = 0; auto_load = 1;
      resync = 1; tick(); resync = 0;
      total++; if (dirty !== 20'hfffff) begin bad++; $display("FAIL resync_dirty: got %h want fffff", dirty); end
      b = fq.size(); d0 = done_cnt; n0 = nl_cnt;
      pulse_start();
      wait_done(3000, d0);
      total++; if (fq.size() - b != 20) begin bad++; $display("FAIL fast_count: got %0d want 20", fq.size() - b); end
      for (int i = 0; i < 20; i++) begin
         exp = {8'(4 + i % 4), (i == 0) ? 16'h0001 : 16'h0000};
         total++;
         if (fq[b+i].dev != i / 4 || fq[b+i].data !== exp || fq[b+i].nbits != 24 || fq[b+i].len != 50 || fq[b+i].minsp != 2 || fq[b+i].maxsp != 2) begin
            bad++;
            $display("FAIL fast_frame%0d: got dev %0d data %h bits %0d len %0d sp %0d..%0d want dev %0d data %h bits 24 len 50 sp 2..2", i, fq[b+i].dev, fq[b+i].data, fq[b+i].nbits, fq[b+i].len, fq[b+i].minsp, fq[b+i].maxsp, i / 4, exp);
         end
      end
      total++; if (nl_cnt - n0 != 1 || nl_last != 4) begin bad++; $display("FAIL fast_nload: got %0d pulses len %0d want 1 len 4", nl_cnt - n0, nl_last); end
      total++; if (dirty !== 20'h0) begin bad++; $display("FAIL fast_end_dirty: got %h want 0", dirty); end
   endtask
   initial begin
      test_reset();
      test_single();
      test_broadcast();
      test_empty();
      test_capture_race();
      test_reset_mid();
      test_fast_div();
      total++; if (multi_cs != 0) begin bad++; $display("FAIL multi_ncs: got %0d cycles want 0", multi_cs); end
      total++; if (stray != 0) begin bad++; $display("FAIL stray_sclk: got %0d cycles want 0", stray); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
